cplx_dot_prod_acc: RTL

- Parametrised successor to the pipelined complex dot-product block in the CAF datapath.
- Accepts paired complex sample streams x and y with full valid/ready backpressure.
- Multiplies each pair, in normal or conjugate mode, and accumulates LENGTH pairs per frame.
- Emits one complex sum per frame on a held output with ready/valid; feeds the CAF lag/peak search.

---
 rtl/cplx_dot_prod_acc.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cplx_dot_prod_acc.sv
// Pipelined complex dot-product accumulator for the CAF lag/peak search.
// Accepts paired x/y complex samples, multiplies (normal or conjugate mode)
// and sums LENGTH pairs per frame into one held complex result.
// Pipeline: S1 input regs -> S2 products -> S3 cross terms -> accumulate/output.
// The whole pipeline advances together only while the output is not blocked.
module cplx_dot_prod_acc #(
    parameter int XI_BITS    = 12,
    parameter int XQ_BITS    = 12,
    parameter int YI_BITS    = 12,
    parameter int YQ_BITS    = 12,
    parameter int LENGTH     = 16,
    parameter int SUM_I_BITS = XI_BITS + YI_BITS + 1 + $clog2(LENGTH),
    parameter int SUM_Q_BITS = XQ_BITS + YI_BITS + 1 + $clog2(LENGTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         conj,
    input  logic                         m_axis_x_tvalid,
    output logic                         m_axis_x_tready,
    input  logic signed [XI_BITS-1:0]    xi,
    input  logic signed [XQ_BITS-1:0]    xq,
    input  logic                         m_axis_y_tvalid,
    output logic                         m_axis_y_tready,
    input  logic signed [YI_BITS-1:0]    yi,
    input  logic signed [YQ_BITS-1:0]    yq,
    output logic                         s_axis_product_tvalid,
    input  logic                         m_axis_product_tready,
    output logic signed [SUM_I_BITS-1:0] i,
    output logic signed [SUM_Q_BITS-1:0] q
);

    localparam int CNT_BITS = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int P_II     = XI_BITS + YI_BITS;
    localparam int P_QQ     = XQ_BITS + YQ_BITS;
    localparam int P_IQ     = XI_BITS + YQ_BITS;
    localparam int P_QI     = XQ_BITS + YI_BITS;
    localparam int P_MAX_A  = (P_II > P_QQ) ? P_II : P_QQ;
    localparam int P_MAX_B  = (P_IQ > P_QI) ? P_IQ : P_QI;
    localparam int P_MAX    = (P_MAX_A > P_MAX_B) ? P_MAX_A : P_MAX_B;
    // one guard bit so the sum/difference of two products never wraps
    localparam int T_BITS   = P_MAX + 1;

    logic en;
    logic accept;
    logic frame_start;
    logic frame_end;

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic conj_lat_q, conj_lat_d;

    logic s1_valid_q, s1_valid_d;
    logic s1_first_q, s1_first_d;
    logic s1_last_q, s1_last_d;
    logic s1_conj_q, s1_conj_d;
    logic signed [XI_BITS-1:0] s1_xi_q, s1_xi_d;
    logic signed [XQ_BITS-1:0] s1_xq_q, s1_xq_d;
    logic signed [YI_BITS-1:0] s1_yi_q, s1_yi_d;
    logic signed [YQ_BITS-1:0] s1_yq_q, s1_yq_d;

    logic s2_valid_q, s2_valid_d;
    logic s2_first_q, s2_first_d;
    logic s2_last_q, s2_last_d;
    logic s2_conj_q, s2_conj_d;
    logic signed [P_II-1:0] p_ii_q, p_ii_d;
    logic signed [P_QQ-1:0] p_qq_q, p_qq_d;
    logic signed [P_IQ-1:0] p_iq_q, p_iq_d;
    logic signed [P_QI-1:0] p_qi_q, p_qi_d;

    logic s3_valid_q, s3_valid_d;
    logic s3_first_q, s3_first_d;
    logic s3_last_q, s3_last_d;
    logic signed [SUM_I_BITS-1:0] term_i_q, term_i_d;
    logic signed [SUM_Q_BITS-1:0] term_q_q, term_q_d;

    logic signed [SUM_I_BITS-1:0] acc_i_q, acc_i_d;
    logic signed [SUM_Q_BITS-1:0] acc_q_q, acc_q_d;
    logic out_valid_q, out_valid_d;
    logic signed [SUM_I_BITS-1:0] out_i_q, out_i_d;
    logic signed [SUM_Q_BITS-1:0] out_q_q, out_q_d;

    logic signed [T_BITS-1:0] re_w;
    logic signed [T_BITS-1:0] im_w;

    assign en          = !(out_valid_q && !m_axis_product_tready);
    assign accept      = en && m_axis_x_tvalid && m_axis_y_tvalid;
    assign frame_start = (cnt_q == '0);
    assign frame_end   = (cnt_q == CNT_BITS'(LENGTH - 1));

    assign m_axis_x_tready       = en;
    assign m_axis_y_tready       = en;
    assign s_axis_product_tvalid = out_valid_q;
    assign i                     = out_i_q;
    assign q                     = out_q_q;

    // Next-state for the frame counter, pipeline stages, accumulator and output.
    always_comb begin
        cnt_d       = cnt_q;
        conj_lat_d  = conj_lat_q;
        s1_valid_d  = s1_valid_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_conj_d   = s1_conj_q;
        s1_xi_d     = s1_xi_q;
        s1_xq_d     = s1_xq_q;
        s1_yi_d     = s1_yi_q;
        s1_yq_d     = s1_yq_q;
        s2_valid_d  = s2_valid_q;
        s2_first_d  = s2_first_q;
        s2_last_d   = s2_last_q;
        s2_conj_d   = s2_conj_q;
        p_ii_d      = p_ii_q;
        p_qq_d      = p_qq_q;
        p_iq_d      = p_iq_q;
        p_qi_d      = p_qi_q;
        s3_valid_d  = s3_valid_q;
        s3_first_d  = s3_first_q;
        s3_last_d   = s3_last_q;
        term_i_d    = term_i_q;
        term_q_d    = term_q_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;

        // cross terms from the registered products; conj flag travels with the pair
        if (s2_conj_q) begin
            re_w = T_BITS'(p_ii_q) + T_BITS'(p_qq_q);
            im_w = T_BITS'(p_qi_q) - T_BITS'(p_iq_q);
        end else begin
            re_w = T_BITS'(p_ii_q) - T_BITS'(p_qq_q);
            im_w = T_BITS'(p_iq_q) + T_BITS'(p_qi_q);
        end

        if (accept) begin
            cnt_d = frame_end ? '0 : cnt_q + 1'b1;
            if (frame_start) begin
                conj_lat_d = conj;
            end
        end

        // a consumed result drops valid; a same-edge load below overrides this
        if (out_valid_q && m_axis_product_tready) begin
            out_valid_d = 1'b0;
        end

        if (en) begin
            s1_valid_d = accept;
            s1_first_d = frame_start;
            s1_last_d  = frame_end;
            s1_conj_d  = frame_start ? conj : conj_lat_q;
            s1_xi_d    = xi;
            s1_xq_d    = xq;
            s1_yi_d    = yi;
            s1_yq_d    = yq;

            s2_valid_d = s1_valid_q;
            s2_first_d = s1_first_q;
            s2_last_d  = s1_last_q;
            s2_conj_d  = s1_conj_q;
            p_ii_d     = P_II'(s1_xi_q) * P_II'(s1_yi_q);
            p_qq_d     = P_QQ'(s1_xq_q) * P_QQ'(s1_yq_q);
            p_iq_d     = P_IQ'(s1_xi_q) * P_IQ'(s1_yq_q);
            p_qi_d     = P_QI'(s1_xq_q) * P_QI'(s1_yi_q);

            s3_valid_d = s2_valid_q;
            s3_first_d = s2_first_q;
            s3_last_d  = s2_last_q;
            term_i_d   = SUM_I_BITS'(re_w);
            term_q_d   = SUM_Q_BITS'(im_w);

            if (s3_valid_q) begin
                acc_i_d = s3_first_q ? term_i_q : acc_i_q + term_i_q;
                acc_q_d = s3_first_q ? term_q_q : acc_q_q + term_q_q;
                if (s3_last_q) begin
                    out_valid_d = 1'b1;
                    out_i_d     = acc_i_d;
                    out_q_d     = acc_q_d;
                end
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            conj_lat_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_conj_q   <= 1'b0;
            s1_xi_q     <= '0;
            s1_xq_q     <= '0;
            s1_yi_q     <= '0;
            s1_yq_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_conj_q   <= 1'b0;
            p_ii_q      <= '0;
            p_qq_q      <= '0;
            p_iq_q      <= '0;
            p_qi_q      <= '0;
            s3_valid_q  <= 1'b0;
            s3_first_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            term_i_q    <= '0;
            term_q_q    <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            conj_lat_q  <= conj_lat_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_conj_q   <= s1_conj_d;
            s1_xi_q     <= s1_xi_d;
            s1_xq_q     <= s1_xq_d;
            s1_yi_q     <= s1_yi_d;
            s1_yq_q     <= s1_yq_d;
            s2_valid_q  <= s2_valid_d;
            s2_first_q  <= s2_first_d;
            s2_last_q   <= s2_last_d;
            s2_conj_q   <= s2_conj_d;
            p_ii_q      <= p_ii_d;
            p_qq_q      <= p_qq_d;
            p_iq_q      <= p_iq_d;
            p_qi_q      <= p_qi_d;
            s3_valid_q  <= s3_valid_d;
            s3_first_q  <= s3_first_d;
            s3_last_q   <= s3_last_d;
            term_i_q    <= term_i_d;
            term_q_q    <= term_q_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
        end
    end

endmodule
